// File: rtl/gpca_iter_pkg.sv
// gpca_iter_pkg
// Shared definitions for the iterative cellular arithmetic core: operation
// codes, FSM state encoding and the per-operation iteration count.
// No ports; imported by the interface-using top and by testbenches.

package gpca_iter_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_SQR  = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_SQRT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } stateType;

    // Division retires one quotient bit per cycle over a 2N-bit dividend;
    // every other op finishes in N row evaluations.
    function automatic int iterCount(input logic [1:0] op, input int n);
        return (op == OP_DIV) ? 2 * n : n;
    endfunction

endpackage

// File: rtl/gpca_iter_if.sv
// gpca_iter_if
// Start/done handshake plus operand and result bus of the iterative core.
// Signals:
//   start  - start request, sampled only while the core is idle
//   op     - operation select (MUL, SQR, DIV, SQRT)
//   a      - 2N-bit operand: multiplicand / dividend / radicand
//   b      - N-bit operand: multiplier / divisor
//   busy   - operation in progress
//   done   - one-cycle completion pulse
//   err    - divide by zero, valid with done
//   result - 2N-bit product, square, quotient or root
//   rem    - N+1-bit remainder
// Modports: master drives the request side, slave is the core.

interface gpca_iter_if #(
    parameter int N = 5
);
    logic           start;
    logic [1:0]     op;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic           err;
    logic [2*N-1:0] result;
    logic [N:0]     rem;

    modport master (
        output start, op, a, b,
        input  busy, done, err, result, rem
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, err, result, rem
    );
endinterface

// File: rtl/gpca_iter_row.sv
// gpca_iter_row
// One controlled add/subtract row of the cellular array, W bits wide.
// Ports:
//   i_sub     - 1: o_sum = i_partial - i_operand, 0: o_sum = i_partial + i_operand
//   i_operand - value added or subtracted
//   i_partial - running partial value
//   o_sum     - W-bit sum/difference (modulo 2^W)
//   o_carry   - carry out; when subtracting, 1 means no borrow (partial >= operand)

module gpca_iter_row #(
    parameter int W = 7
) (
    input  logic         i_sub,
    input  logic [W-1:0] i_operand,
    input  logic [W-1:0] i_partial,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);
    logic [W:0] w_total;

    // Subtraction is the two's complement add: invert the operand and feed
    // the sub bit in as the carry-in, exactly like a chain of CAS cells.
    assign w_total = {1'b0, i_partial}
                   + {1'b0, i_operand ^ {W{i_sub}}}
                   + {{W{1'b0}}, i_sub};

    assign o_sum   = w_total[W-1:0];
    assign o_carry = w_total[W];

endmodule

// File: rtl/gpca_iter.sv
// gpca_iter
// Iterative multiply / square / divide / square-root core. One array row is
// evaluated per clock through a single shared add/subtract row.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - gpca_iter_if slave: start/op/a/b in, busy/done/err/result/rem out

module gpca_iter
    import gpca_iter_pkg::*;
#(
    parameter int N = 5
) (
    input  logic       clk,
    input  logic       rst,
    gpca_iter_if.slave bus
);
    localparam int W  = N + 2;
    localparam int CW = $clog2(2 * N + 1);

    stateType       r_state;
    stateType       w_nextState;

    logic [1:0]     r_op;
    logic [N-1:0]   r_opB;
    logic [2*N-1:0] r_acc;
    logic [W-1:0]   r_part;
    logic [N-1:0]   r_root;
    logic [CW-1:0]  r_cnt;
    logic           r_divZero;
    logic           r_done;
    logic           r_err;
    logic [2*N-1:0] r_result;
    logic [N:0]     r_rem;

    logic           w_accept;
    logic           w_step;
    logic           w_finish;
    logic           w_busy;
    logic           w_startDivZero;

    logic           w_rowSub;
    logic [W-1:0]   w_rowOperand;
    logic [W-1:0]   w_rowPartial;
    logic [W-1:0]   w_rowSum;
    logic           w_rowCarry;
    logic [N:0]     w_divRem;
    logic [N:0]     w_sqrtRem;

    assign w_startDivZero = (bus.op == OP_DIV) && (bus.b == '0);

    gpca_iter_row #(.W(W)) u_row (
        .i_sub     (w_rowSub),
        .i_operand (w_rowOperand),
        .i_partial (w_rowPartial),
        .o_sum     (w_rowSum),
        .o_carry   (w_rowCarry)
    );

    // State register. Reset always wins, so a start in the reset cycle is lost
    // and a running operation is abandoned without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A divide by zero has nothing to iterate, so it jumps
    // straight to DONE; otherwise RUN lasts until the counter reaches one.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_nextState = w_startDivZero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the state. Start is only honoured in IDLE,
    // which is what makes a start during RUN or DONE harmless.
    always_comb begin
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            ST_IDLE: w_accept = bus.start;
            ST_RUN: begin
                w_step = 1'b1;
                w_busy = 1'b1;
            end
            ST_DONE: begin
                w_finish = 1'b1;
                w_busy   = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    // Operand steering for the shared row. The square-root remainder is kept
    // modulo 2^(N+2); intermediate shifts may overflow but every stored
    // remainder fits that signed range, so the wrap-around is harmless.
    // In DONE the same row performs the square-root sign correction.
    always_comb begin
        w_rowSub     = 1'b0;
        w_rowOperand = '0;
        w_rowPartial = '0;
        case (r_op)
            OP_MUL, OP_SQR: begin
                w_rowPartial = {2'b00, r_acc[2*N-1:N]};
                w_rowOperand = r_acc[0] ? {2'b00, r_opB} : '0;
            end
            OP_DIV: begin
                w_rowSub     = 1'b1;
                w_rowPartial = {1'b0, r_part[N-1:0], r_acc[2*N-1]};
                w_rowOperand = {2'b00, r_opB};
            end
            default: begin
                if (w_finish) begin
                    w_rowPartial = r_part;
                    w_rowOperand = {1'b0, r_root, 1'b1};
                end else begin
                    w_rowSub     = ~r_part[W-1];
                    w_rowPartial = {r_part[N-1:0], r_acc[2*N-1:2*N-2]};
                    w_rowOperand = r_part[W-1] ? {r_root, 2'b11} : {r_root, 2'b01};
                end
            end
        endcase
    end

    // Restoring division keeps the shifted value when the trial subtract
    // borrows; the root remainder is corrected only if it ended negative.
    assign w_divRem  = w_rowCarry ? w_rowSum[N:0] : w_rowPartial[N:0];
    assign w_sqrtRem = r_part[W-1] ? w_rowSum[N:0] : r_part[N:0];

    // Datapath and registered outputs. Operands are captured once on accept
    // so later bus changes cannot disturb a running operation. result, rem
    // and err are only written on completion (err is also cleared on accept)
    // so they stay visible while the core sits idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_opB     <= '0;
            r_acc     <= '0;
            r_part    <= '0;
            r_root    <= '0;
            r_cnt     <= '0;
            r_divZero <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_result  <= '0;
            r_rem     <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_op      <= bus.op;
                r_opB     <= (bus.op == OP_SQR) ? bus.a[N-1:0] : bus.b;
                r_acc     <= bus.op[1] ? bus.a : {{N{1'b0}}, bus.a[N-1:0]};
                r_part    <= '0;
                r_root    <= '0;
                r_cnt     <= CW'(iterCount(bus.op, N));
                r_divZero <= w_startDivZero;
                r_err     <= 1'b0;
            end

            if (w_step) begin
                r_cnt <= r_cnt - CW'(1);
                case (r_op)
                    OP_MUL, OP_SQR: begin
                        r_acc <= {w_rowSum[N:0], r_acc[N-1:1]};
                    end
                    OP_DIV: begin
                        r_part <= {1'b0, w_divRem};
                        r_acc  <= {r_acc[2*N-2:0], w_rowCarry};
                    end
                    default: begin
                        r_part <= w_rowSum;
                        r_root <= {r_root[N-2:0], ~w_rowSum[W-1]};
                        r_acc  <= {r_acc[2*N-3:0], 2'b00};
                    end
                endcase
            end

            if (w_finish) begin
                r_done <= 1'b1;
                if (r_divZero) begin
                    r_result <= '1;
                    r_rem    <= '0;
                    r_err    <= 1'b1;
                end else begin
                    case (r_op)
                        OP_MUL, OP_SQR: begin
                            r_result <= r_acc;
                            r_rem    <= '0;
                        end
                        OP_DIV: begin
                            r_result <= r_acc;
                            r_rem    <= r_part[N:0];
                        end
                        default: begin
                            r_result <= {{N{1'b0}}, r_root};
                            r_rem    <= w_sqrtRem;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;
    assign bus.rem    = r_rem;

endmodule

// File: tb/tb_gpca_iter.sv
// tb_gpca_iter
// Self-checking bench for gpca_iter at N=5 and N=8: directed cases plus a
// random regression, each compared against an arithmetic reference model.

module tb_gpca_iter;
    import gpca_iter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    gpca_iter_if #(.N(5)) if5 ();
    gpca_iter_if #(.N(8)) if8 ();

    gpca_iter #(.N(5)) u_dut5 (.clk(clk), .rst(rst), .bus(if5));
    gpca_iter #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] expResult, expRem, expErr, expLat;
    logic [31:0] obsResult, obsRem, obsErr, obsLat, obsBusyStart, obsBusyDone;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference model: plain integer arithmetic on the masked operands.
    task automatic computeExpected(input int n, input logic [1:0] op,
                                   input logic [15:0] a, input logic [7:0] b);
        int aw, bw, lo, r;
        aw = int'(a) % (1 << (2 * n));
        bw = int'(b) % (1 << n);
        lo = aw % (1 << n);
        expErr = 0;
        expRem = 0;
        case (op)
            OP_MUL: expResult = 32'(lo * bw);
            OP_SQR: expResult = 32'(lo * lo);
            OP_DIV: begin
                if (bw == 0) begin
                    expResult = 32'((1 << (2 * n)) - 1);
                    expErr    = 1;
                end else begin
                    expResult = 32'(aw / bw);
                    expRem    = 32'(aw % bw);
                end
            end
            default: begin
                r = 0;
                while ((r + 1) * (r + 1) <= aw) r++;
                expResult = 32'(r);
                expRem    = 32'(aw - r * r);
            end
        endcase
        if (op == OP_DIV && bw == 0) expLat = 1;
        else if (op == OP_DIV)       expLat = 32'(2 * n + 1);
        else                         expLat = 32'(n + 1);
    endtask

    task automatic driveInputs(input int n, input logic s, input logic [1:0] op,
                               input logic [15:0] a, input logic [7:0] b);
        if (n == 5) begin
            if5.start = s;
            if5.op    = op;
            if5.a     = a[9:0];
            if5.b     = b[4:0];
        end else begin
            if8.start = s;
            if8.op    = op;
            if8.a     = a;
            if8.b     = b;
        end
    endtask

    task automatic driveNoise(input int n);
        driveInputs(n, 1'b0, 2'($urandom), 16'($urandom), 8'($urandom));
    endtask

    function automatic logic readDone(input int n);
        return (n == 5) ? if5.done : if8.done;
    endfunction

    function automatic logic readBusy(input int n);
        return (n == 5) ? if5.busy : if8.busy;
    endfunction

    function automatic logic [31:0] readResult(input int n);
        return (n == 5) ? 32'(if5.result) : 32'(if8.result);
    endfunction

    function automatic logic [31:0] readRem(input int n);
        return (n == 5) ? 32'(if5.rem) : 32'(if8.rem);
    endfunction

    function automatic logic readErr(input int n);
        return (n == 5) ? if5.err : if8.err;
    endfunction

    // Issues one operation, scrambles the inputs right after acceptance,
    // optionally pulses a spurious start after pokeAt cycles, waits (bounded)
    // for done and checks every output against the model.
    task automatic applyStimulus(input int n, input logic [1:0] op, input logic [15:0] a,
                                 input logic [7:0] b, input int pokeAt, input string tag);
        int lat;
        bit seen;
        computeExpected(n, op, a, b);
        @(negedge clk);
        driveInputs(n, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        driveNoise(n);
        obsBusyStart = 32'(readBusy(n));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (lat == pokeAt) driveInputs(n, 1'b1, ~op, ~a, ~b);
            @(posedge clk);
            #1;
            lat++;
            driveNoise(n);
            seen = readDone(n);
        end
        obsLat      = seen ? 32'(lat) : 32'd0;
        obsResult   = readResult(n);
        obsRem      = readRem(n);
        obsErr      = 32'(readErr(n));
        obsBusyDone = 32'(readBusy(n));
        checkOutput({tag, ".latency"}, obsLat, expLat);
        checkOutput({tag, ".result"}, obsResult, expResult);
        checkOutput({tag, ".rem"}, obsRem, expRem);
        checkOutput({tag, ".err"}, obsErr, expErr);
        checkOutput({tag, ".busyStart"}, obsBusyStart, 32'd1);
        checkOutput({tag, ".busyDone"}, obsBusyDone, 32'd0);
    endtask

    // Counts done pulses over a window in which none may occur.
    task automatic checkQuiet(input int n, input int cycles, input string tag);
        int pulses = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (readDone(n)) pulses++;
        end
        checkOutput(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        driveInputs(5, 1'b0, OP_MUL, 16'd0, 8'd0);
        driveInputs(8, 1'b0, OP_MUL, 16'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.result", readResult(5), 32'd0);
        checkOutput("reset.rem", readRem(5), 32'd0);
        checkOutput("reset.busy", 32'(readBusy(5)), 32'd0);
        checkOutput("reset.done", 32'(readDone(5)), 32'd0);
        checkOutput("reset.err", 32'(readErr(5)), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed cases, N=5");
        applyStimulus(5, OP_MUL, 16'd5, 8'd7, -1, "mul5x7");
        applyStimulus(5, OP_SQR, 16'd5, 8'd31, -1, "sqr5");
        applyStimulus(5, OP_SQRT, 16'd25, 8'd0, -1, "sqrt25");
        applyStimulus(5, OP_SQRT, 16'd30, 8'd0, -1, "sqrt30");
        applyStimulus(5, OP_DIV, 16'd35, 8'd5, -1, "div35by5");
        applyStimulus(5, OP_DIV, 16'd1023, 8'd1, -1, "div1023by1");
        applyStimulus(5, OP_DIV, 16'd100, 8'd0, -1, "divByZero");
        applyStimulus(5, OP_MUL, 16'd6, 8'd9, -1, "mulClearsErr");
        applyStimulus(5, OP_SQRT, 16'd1023, 8'd0, -1, "sqrtMax");
        applyStimulus(5, OP_DIV, 16'd1023, 8'd31, -1, "divMaxOperands");

        $display("[TB] spurious start during RUN and DONE");
        applyStimulus(5, OP_MUL, 16'd3, 8'd9, 2, "pokeRun");
        checkQuiet(5, 15, "pokeRun.extraDone");
        checkOutput("pokeRun.resultHeld", readResult(5), 32'd27);
        applyStimulus(5, OP_SQR, 16'd6, 8'd0, 5, "pokeDone");
        checkQuiet(5, 15, "pokeDone.extraDone");

        $display("[TB] reset in the middle of a divide");
        @(negedge clk);
        driveInputs(5, 1'b1, OP_DIV, 16'd1000, 8'd7);
        @(posedge clk);
        #1;
        driveNoise(5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        driveInputs(5, 1'b1, OP_MUL, 16'd3, 8'd3);
        @(posedge clk);
        #1;
        checkOutput("rstMid.result", readResult(5), 32'd0);
        checkOutput("rstMid.rem", readRem(5), 32'd0);
        checkOutput("rstMid.err", 32'(readErr(5)), 32'd0);
        checkOutput("rstMid.busy", 32'(readBusy(5)), 32'd0);
        checkOutput("rstMid.done", 32'(readDone(5)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        driveNoise(5);
        checkQuiet(5, 30, "rstMid.noDone");
        applyStimulus(5, OP_MUL, 16'd31, 8'd31, -1, "mul31x31");

        $display("[TB] directed cases, N=8");
        applyStimulus(8, OP_MUL, 16'd255, 8'd255, -1, "n8.mulMax");
        applyStimulus(8, OP_DIV, 16'd65535, 8'd1, -1, "n8.divBy1");
        applyStimulus(8, OP_SQRT, 16'd65535, 8'd0, -1, "n8.sqrtMax");
        applyStimulus(8, OP_DIV, 16'd500, 8'd0, -1, "n8.divByZero");

        $display("[TB] random regression");
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) begin
                int n;
                logic [1:0] op;
                logic [15:0] a;
                logic [7:0] b;
                n  = (k == 0) ? 5 : 8;
                op = 2'($urandom_range(0, 3));
                a  = 16'($urandom);
                b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                applyStimulus(n, op, a, b, -1, $sformatf("rand%0d.n%0d.op%0d", i, n, op));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
